// File: rtl/dma_desc_chainer.sv
// Scatter-gather chainer: walks a linked list of 4-word descriptors and programs a DMA controller per entry.
// Define DESC_IRQ_EN to add the oIrq completion interrupt (control bit1 enables it).
module dma_desc_chainer #(
  parameter logic [2:0]  RM_ADDR_REG = 3'd0,
  parameter logic [2:0]  WM_ADDR_REG = 3'd1,
  parameter logic [2:0]  LEN_REG     = 3'd2,
  parameter logic [2:0]  START_REG   = 3'd3,
  parameter logic [2:0]  STATUS_REG  = 3'd4,
  parameter int unsigned POLL_GAP    = 8
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipselect,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [1:0]  iAddress,
  input  logic [31:0] iWritedata,
  output logic [31:0] oReaddata,
  output logic        oDR_read,
  output logic [31:0] oDR_address,
  input  logic        iDR_waitrequest,
  input  logic        iDR_readdatavalid,
  input  logic [31:0] iDR_readdata,
  output logic        oCM_write,
  output logic        oCM_read,
  output logic [2:0]  oCM_address,
  output logic [31:0] oCM_writedata,
  input  logic [31:0] iCM_readdata
`ifdef DESC_IRQ_EN
  ,
  output logic        oIrq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAITD, S_PROG, S_POLL, S_POLLWAIT, S_GAP, S_NEXT
  } state_e;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic [31:0] head_q, head_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] desc_q [4];
  logic [31:0] desc_d [4];
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  prog_q, prog_d;
  logic [7:0]  gap_q, gap_d;
  logic        dr_read_q, dr_read_d;
  logic [31:0] dr_address_q, dr_address_d;
  logic        cm_write_q, cm_write_d;
  logic        cm_read_q, cm_read_d;
  logic [2:0]  cm_address_q, cm_address_d;
  logic [31:0] cm_writedata_q, cm_writedata_d;
`ifdef DESC_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
`endif

  logic        slave_wr;
  logic        go;
  logic [1:0]  idx_next;
  logic        unused_inputs;

  assign slave_wr      = iChipselect & iWrite;
  assign go            = slave_wr && (iAddress == 2'd1) && iWritedata[0];
  assign idx_next      = idx_q + 2'd1;
  // Only the done bit of the DMA status word matters; iRead is implied by the combinational readback.
  assign unused_inputs = ^{iRead, iCM_readdata[31:1]};

  always_comb begin
    // NOTE: every _d starts from its _q (strobes from 0) so no branch can leave one unassigned and infer a latch.
    state_d        = state_q;
    head_d         = head_q;
    ptr_d          = ptr_q;
    count_d        = count_q;
    busy_d         = busy_q;
    done_d         = done_q;
    desc_d         = desc_q;
    idx_d          = idx_q;
    prog_d         = prog_q;
    gap_d          = gap_q;
    dr_read_d      = dr_read_q;
    dr_address_d   = dr_address_q;
    cm_write_d     = 1'b0;
    cm_read_d      = 1'b0;
    cm_address_d   = cm_address_q;
    cm_writedata_d = cm_writedata_q;

    if (slave_wr && iAddress == 2'd0) head_d = iWritedata;
    if (slave_wr && iAddress == 2'd2 && iWritedata[1]) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (head_q != 32'd0) begin
            busy_d       = 1'b1;
            done_d       = 1'b0;
            count_d      = 32'd0;
            ptr_d        = head_q;
            idx_d        = 2'd0;
            dr_read_d    = 1'b1;
            dr_address_d = head_q;
            state_d      = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (!iDR_waitrequest) begin
          dr_read_d = 1'b0;
          state_d   = S_WAITD;
        end
      end
      S_WAITD: begin
        if (iDR_readdatavalid) begin
          desc_d[idx_q] = iDR_readdata;
          if (idx_q == 2'd3) begin
            // Length word is already captured; a zero-length entry is counted but never programmed.
            if (desc_q[2] == 32'd0) begin
              state_d = S_NEXT;
            end else begin
              prog_d         = 2'd0;
              cm_write_d     = 1'b1;
              cm_address_d   = RM_ADDR_REG;
              cm_writedata_d = desc_q[0];
              state_d        = S_PROG;
            end
          end else begin
            idx_d        = idx_next;
            dr_read_d    = 1'b1;
            dr_address_d = ptr_q + {28'd0, idx_next, 2'b00};
            state_d      = S_FETCH;
          end
        end
      end
      S_PROG: begin
        if (prog_q == 2'd3) begin
          cm_read_d    = 1'b1;
          cm_address_d = STATUS_REG;
          state_d      = S_POLL;
        end else begin
          prog_d     = prog_q + 2'd1;
          cm_write_d = 1'b1;
          case (prog_q)
            2'd0: begin
              cm_address_d   = WM_ADDR_REG;
              cm_writedata_d = desc_q[1];
            end
            2'd1: begin
              cm_address_d   = LEN_REG;
              cm_writedata_d = desc_q[2];
            end
            default: begin
              cm_address_d   = START_REG;
              cm_writedata_d = 32'd1;
            end
          endcase
        end
      end
      S_POLL: state_d = S_POLLWAIT;
      S_POLLWAIT: begin
        if (iCM_readdata[0]) begin
          state_d = S_NEXT;
        end else begin
          gap_d   = 8'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          cm_read_d    = 1'b1;
          cm_address_d = STATUS_REG;
          state_d      = S_POLL;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin  // S_NEXT
        count_d = count_q + 32'd1;
        ptr_d   = desc_q[3];
        if (desc_q[3] == 32'd0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d        = 2'd0;
          dr_read_d    = 1'b1;
          dr_address_d = desc_q[3];
          state_d      = S_FETCH;
        end
      end
    endcase
  end

`ifdef DESC_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (slave_wr && iAddress == 2'd1) irq_en_d = iWritedata[1];
    irq_d = done_d & irq_en_d;
  end
`endif

  // NOTE: state flops use non-blocking assignment only, so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q        <= S_IDLE;
      head_q         <= '0;
      ptr_q          <= '0;
      count_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      // NOTE: desc is a 4-entry register file rather than a RAM, so it is reset with the rest of the state.
      desc_q         <= '{default: '0};
      idx_q          <= '0;
      prog_q         <= '0;
      gap_q          <= '0;
      dr_read_q      <= 1'b0;
      dr_address_q   <= '0;
      cm_write_q     <= 1'b0;
      cm_read_q      <= 1'b0;
      cm_address_q   <= '0;
      cm_writedata_q <= '0;
`ifdef DESC_IRQ_EN
      irq_en_q       <= 1'b0;
      irq_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      ptr_q          <= ptr_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      desc_q         <= desc_d;
      idx_q          <= idx_d;
      prog_q         <= prog_d;
      gap_q          <= gap_d;
      dr_read_q      <= dr_read_d;
      dr_address_q   <= dr_address_d;
      cm_write_q     <= cm_write_d;
      cm_read_q      <= cm_read_d;
      cm_address_q   <= cm_address_d;
      cm_writedata_q <= cm_writedata_d;
`ifdef DESC_IRQ_EN
      irq_en_q       <= irq_en_d;
      irq_q          <= irq_d;
`endif
    end
  end

  always_comb begin
    case (iAddress)
      2'd0:    oReaddata = head_q;
`ifdef DESC_IRQ_EN
      2'd1:    oReaddata = {30'd0, irq_en_q, 1'b0};
`else
      2'd1:    oReaddata = 32'd0;
`endif
      2'd2:    oReaddata = {30'd0, done_q, busy_q};
      default: oReaddata = count_q;
    endcase
  end

  assign oDR_read      = dr_read_q;
  assign oDR_address   = dr_address_q;
  assign oCM_write     = cm_write_q;
  assign oCM_read      = cm_read_q;
  assign oCM_address   = cm_address_q;
  assign oCM_writedata = cm_writedata_q;
`ifdef DESC_IRQ_EN
  assign oIrq          = irq_q;
`endif

endmodule

// File: tb/tb_dma_desc_chainer.sv
// Directed bench for dma_desc_chainer: descriptor memory and DMA controller models plus linear test steps.
`timescale 1ns/1ps
module tb_dma_desc_chainer;

  localparam int POLL_GAP = 8;
  localparam int DMA_LAT  = 20;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b1;
  logic        iChipselect = 1'b0;
  logic        iRead = 1'b0;
  logic        iWrite = 1'b0;
  logic [1:0]  iAddress = 2'd0;
  logic [31:0] iWritedata = 32'd0;
  logic [31:0] oReaddata;
  logic        oDR_read;
  logic [31:0] oDR_address;
  logic        iDR_waitrequest = 1'b0;
  logic        iDR_readdatavalid = 1'b0;
  logic [31:0] iDR_readdata = 32'd0;
  logic        oCM_write;
  logic        oCM_read;
  logic [2:0]  oCM_address;
  logic [31:0] oCM_writedata;
  logic [31:0] iCM_readdata = 32'd0;
`ifdef DESC_IRQ_EN
  logic        oIrq;
`endif

  dma_desc_chainer dut (
    .iClk              (iClk),
    .iReset_n          (iReset_n),
    .iChipselect       (iChipselect),
    .iRead             (iRead),
    .iWrite            (iWrite),
    .iAddress          (iAddress),
    .iWritedata        (iWritedata),
    .oReaddata         (oReaddata),
    .oDR_read          (oDR_read),
    .oDR_address       (oDR_address),
    .iDR_waitrequest   (iDR_waitrequest),
    .iDR_readdatavalid (iDR_readdatavalid),
    .iDR_readdata      (iDR_readdata),
    .oCM_write         (oCM_write),
    .oCM_read          (oCM_read),
    .oCM_address       (oCM_address),
    .oCM_writedata     (oCM_writedata),
    .iCM_readdata      (iCM_readdata)
`ifdef DESC_IRQ_EN
    ,
    .oIrq              (oIrq)
`endif
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Descriptor memory (read master side)
  logic [31:0] mem [logic [31:0]];
  logic        rd_pend = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  int          dr_reads = 0;
  int          stall_req = 0;
  int          stall_obs = 0;
  int          stall_bad = 0;
  logic        stall_closed = 1'b0;
  logic [31:0] stall_addr = 32'd0;

  always @(negedge iClk) begin
    iDR_readdatavalid = 1'b0;
    if (rd_pend) begin
      iDR_readdatavalid = 1'b1;
      iDR_readdata = mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF;
      rd_pend = 1'b0;
    end
    iDR_waitrequest = 1'b0;
    if (oDR_read) begin
      if (stall_obs < stall_req) begin
        if (stall_obs == 0) stall_addr = oDR_address;
        else if (oDR_address !== stall_addr) stall_bad++;
        stall_obs++;
        iDR_waitrequest = 1'b1;
      end else begin
        if (stall_obs > 0 && !stall_closed) begin
          if (oDR_address !== stall_addr) stall_bad++;
          stall_closed = 1'b1;
        end
        rd_addr = oDR_address;
        rd_pend = 1'b1;
        dr_reads++;
      end
    end else if (stall_obs > 0 && !stall_closed) begin
      stall_bad++;
    end
  end

  // DMA controller model: logs writes and polls, reports done DMA_LAT cycles after Start
  logic [34:0] cm_log [$];
  int          poll_log [$];
  int          cm_strobes = 0;
  int          both_bad = 0;
  int          dma_start = 0;
  logic        dma_armed = 1'b0;
  logic        cm_rd_pend = 1'b0;
  logic        cm_rd_val = 1'b0;

  always @(negedge iClk) begin
    iCM_readdata = cm_rd_pend ? {31'd0, cm_rd_val} : 32'd0;
    cm_rd_pend = 1'b0;
    if (oCM_read && oCM_write) both_bad++;
    if (oCM_write) begin
      cm_log.push_back({oCM_address, oCM_writedata});
      cm_strobes++;
      if (oCM_address == 3'd3 && oCM_writedata == 32'd1) begin
        dma_start = cyc;
        dma_armed = 1'b1;
      end
    end
    if (oCM_read) begin
      poll_log.push_back(cyc);
      cm_strobes++;
      cm_rd_pend = 1'b1;
      cm_rd_val = (oCM_address == 3'd4) && dma_armed && (cyc - dma_start >= DMA_LAT);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sw(input logic [1:0] a, input logic [31:0] d);
    @(negedge iClk);
    iChipselect = 1'b1; iWrite = 1'b1; iAddress = a; iWritedata = d;
    @(negedge iClk);
    iChipselect = 1'b0; iWrite = 1'b0; iWritedata = 32'd0;
  endtask

  task automatic sr(input logic [1:0] a, output logic [31:0] d);
    iChipselect = 1'b1; iRead = 1'b1; iAddress = a;
    #1;
    d = oReaddata;
    iChipselect = 1'b0; iRead = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge iClk);
      iAddress = 2'd2;
      #1;
      if (oReaddata[1:0] == 2'b10) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_prog(input string tag, input int i0, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len);
    check({tag, "_rm"},    cm_log[i0],     {3'd0, src});
    check({tag, "_wm"},    cm_log[i0 + 1], {3'd1, dst});
    check({tag, "_len"},   cm_log[i0 + 2], {3'd2, len});
    check({tag, "_start"}, cm_log[i0 + 3], {3'd3, 32'd1});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int wbase, pbase, snap_dr, snap_cm;
    logic seen;

    mem[32'h100] = 32'h1000; mem[32'h104] = 32'h2000; mem[32'h108] = 32'd64;  mem[32'h10C] = 32'h0;
    mem[32'h200] = 32'h1100; mem[32'h204] = 32'h2100; mem[32'h208] = 32'd128; mem[32'h20C] = 32'h300;
    mem[32'h300] = 32'h1200; mem[32'h304] = 32'h2200; mem[32'h308] = 32'd32;  mem[32'h30C] = 32'h0;

    // Reset state
    #2 iReset_n = 1'b0;
    repeat (3) @(negedge iClk);
    check("rst_dr", {oDR_read, oDR_address}, 33'd0);
    check("rst_cm", {oCM_write, oCM_read, oCM_address, oCM_writedata}, 37'd0);
    sr(2'd2, rd); check("rst_status", rd, 32'd0);
    sr(2'd3, rd); check("rst_count", rd, 32'd0);
    sr(2'd0, rd); check("rst_head", rd, 32'd0);
    @(negedge iClk) iReset_n = 1'b1;

    // Single descriptor at 0x100
    wbase = cm_log.size(); pbase = poll_log.size();
    sw(2'd0, 32'h100);
    sw(2'd1, 32'h1);
    wait_done("t1_done", 600);
    check("t1_nwrites", cm_log.size() - wbase, 4);
    check_prog("t1", wbase, 32'h1000, 32'h2000, 32'd64);
    check("t1_npolls", poll_log.size() - pbase, 3);
    check("t1_poll_after_start", poll_log[pbase] - dma_start + 20, 21);
    check("t1_poll_gap_a", poll_log[pbase + 1] - poll_log[pbase], POLL_GAP + 2);
    check("t1_poll_gap_b", poll_log[pbase + 2] - poll_log[pbase + 1], POLL_GAP + 2);
    sr(2'd2, rd); check("t1_status", rd, 32'd2);
    sr(2'd3, rd); check("t1_count", rd, 32'd1);
    check("t1_dr_reads", dr_reads, 4);

    // Three-entry chain 0x100 -> 0x200 -> 0x300
    mem[32'h10C] = 32'h200;
    wbase = cm_log.size();
    sw(2'd1, 32'h1);
    wait_done("t2_done", 1500);
    check("t2_nwrites", cm_log.size() - wbase, 12);
    check_prog("t2a", wbase,     32'h1000, 32'h2000, 32'd64);
    check_prog("t2b", wbase + 4, 32'h1100, 32'h2100, 32'd128);
    check_prog("t2c", wbase + 8, 32'h1200, 32'h2200, 32'd32);
    sr(2'd3, rd); check("t2_count", rd, 32'd3);
    sr(2'd2, rd); check("t2_status", rd, 32'd2);

    // Middle descriptor has zero length
    mem[32'h208] = 32'd0;
    wbase = cm_log.size(); pbase = poll_log.size();
    sw(2'd1, 32'h1);
    wait_done("t3_done", 1500);
    check("t3_nwrites", cm_log.size() - wbase, 8);
    check_prog("t3a", wbase,     32'h1000, 32'h2000, 32'd64);
    check_prog("t3c", wbase + 4, 32'h1200, 32'h2200, 32'd32);
    check("t3_npolls", poll_log.size() - pbase, 6);
    sr(2'd3, rd); check("t3_count", rd, 32'd3);

    // Waitrequest held for 5 cycles on the first fetch
    wbase = cm_log.size();
    sw(2'd0, 32'h300);
    stall_req = 5;
    sw(2'd1, 32'h1);
    wait_done("t4_done", 600);
    check("t4_stall_cycles", stall_obs, 5);
    check("t4_stall_stable", stall_bad, 0);
    check("t4_stall_addr", stall_addr, 32'h300);
    check("t4_nwrites", cm_log.size() - wbase, 4);
    check_prog("t4", wbase, 32'h1200, 32'h2200, 32'd32);
    sr(2'd3, rd); check("t4_count", rd, 32'd1);

    // Go while busy is ignored
    wbase = cm_log.size();
    sw(2'd0, 32'h100);
    sw(2'd1, 32'h1);
    repeat (30) @(negedge iClk);
    sr(2'd2, rd); check("t5_busy", rd, 32'd1);
    sw(2'd1, 32'h1);
    wait_done("t5_done", 1500);
    check("t5_nwrites", cm_log.size() - wbase, 8);
    check("t5_first_write", cm_log[wbase], {3'd0, 32'h1000});
    sr(2'd3, rd); check("t5_count", rd, 32'd3);

    // Done is write-1-to-clear; go with head = 0 completes at once with no bus traffic
    sw(2'd2, 32'h2);
    sr(2'd2, rd); check("t5_w1c", rd, 32'd0);
    sw(2'd0, 32'h0);
    snap_dr = dr_reads; snap_cm = cm_strobes;
    sw(2'd1, 32'h1);
    sr(2'd2, rd); check("t5_null_done", rd, 32'd2);
    repeat (5) @(negedge iClk);
    check("t5_null_dr", dr_reads, snap_dr);
    check("t5_null_cm", cm_strobes, snap_cm);

    // Reset during POLL, then restart from a fresh head
    sw(2'd0, 32'h300);
    sw(2'd1, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge iClk);
      #1;
      if (oCM_read) seen = 1'b1;
    end
    check("t6_reached_poll", seen, 1'b1);
    iReset_n = 1'b0;
    #1;
    check("t6_rst_dr", {oDR_read, oDR_address}, 33'd0);
    check("t6_rst_cm", {oCM_write, oCM_read, oCM_address, oCM_writedata}, 37'd0);
    sr(2'd2, rd); check("t6_rst_status", rd, 32'd0);
    @(negedge iClk) iReset_n = 1'b1;
    wbase = cm_log.size();
    sw(2'd0, 32'h100);
    sw(2'd1, 32'h1);
    wait_done("t6_done", 1500);
    check("t6_nwrites", cm_log.size() - wbase, 8);
    check_prog("t6", wbase, 32'h1000, 32'h2000, 32'd64);
    sr(2'd3, rd); check("t6_count", rd, 32'd3);

`ifdef DESC_IRQ_EN
    // Interrupt rises with done when enabled and clears with done
    sw(2'd2, 32'h2);
    sw(2'd0, 32'h300);
    check("t7_irq_idle", oIrq, 1'b0);
    sw(2'd1, 32'h3);
    check("t7_irq_busy", oIrq, 1'b0);
    wait_done("t7_done", 600);
    check("t7_irq_set", oIrq, 1'b1);
    sw(2'd2, 32'h2);
    #1;
    check("t7_irq_clr", oIrq, 1'b0);
`endif

    check("rd_wr_exclusive", both_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
